// File: rtl/lc3b_types.sv
// Shared LC-3b types for the fetch pipeline: the machine word and fetch FSM states.
`default_nettype none

package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        SQUASH = 2'd1,
        HOLD   = 2'd2
    } fetch_state_t;

    localparam lc3b_word PC_STEP = 16'd2;

    // Instruction addresses are halfword aligned; bit 0 of any target is dropped.
    function automatic lc3b_word align_pc(input lc3b_word pc);
        return {pc[15:1], 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_skid.sv
// fetch_skid_buffer: output slot plus one-entry skid slot between fetch and decode.
`default_nettype none

module fetch_skid_buffer
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [15:0] load_inst_i,
    input  logic [15:0] load_pc_i,
    input  logic        flush_i,
    input  logic        id_stall_i,
    output logic        consume_o,
    output logic        slot_free_o,
    output logic        if_valid_o,
    output logic [15:0] if_inst_o,
    output logic [15:0] if_pc_o
);

    logic     out_valid_q;
    lc3b_word out_inst_q;
    lc3b_word out_pc_q;
    logic     skid_valid_q;
    lc3b_word skid_inst_q;
    lc3b_word skid_pc_q;

    assign consume_o   = out_valid_q && !id_stall_i;
    assign slot_free_o = !out_valid_q || consume_o;

    assign if_valid_o = out_valid_q;
    assign if_inst_o  = out_inst_q;
    assign if_pc_o    = out_pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_inst_q   <= '0;
            out_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_inst_q  <= '0;
            skid_pc_q    <= '0;
        end else if (flush_i) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (load_i) begin
            // The fetch FSM never loads while the skid is occupied.
            if (slot_free_o) begin
                out_valid_q <= 1'b1;
                out_inst_q  <= load_inst_i;
                out_pc_q    <= load_pc_i;
            end else begin
                skid_valid_q <= 1'b1;
                skid_inst_q  <= load_inst_i;
                skid_pc_q    <= load_pc_i;
            end
        end else if (consume_o) begin
            out_valid_q  <= skid_valid_q;
            out_inst_q   <= skid_inst_q;
            out_pc_q     <= skid_pc_q;
            skid_valid_q <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// fetch_stage: LC-3b fetch PC, I-cache handshake, redirect squash and decode hand-off.
// Define FETCH_PERF_CNT_EN to build the fetch/squash performance counters.
`default_nettype none

module fetch_stage
    import lc3b_types::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        icache_read,
    output logic [15:0] icache_address,
    input  logic        icache_resp,
    input  logic [15:0] icache_rdata,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        if_valid,
    output logic [15:0] if_inst,
    output logic [15:0] if_pc,
    output logic [31:0] if_fetch_count,
    output logic [31:0] if_squash_count
);

    fetch_state_t state_q;
    lc3b_word     pc_q;
    lc3b_word     pending_pc_q;

    lc3b_word pc_inc;
    lc3b_word redirect_target;
    logic     load;
    logic     consume;
    logic     slot_free;

    assign pc_inc          = pc_q + PC_STEP;
    assign redirect_target = align_pc(redirect_pc);
    assign load            = (state_q == FETCH) && icache_resp && !redirect_valid;

    assign icache_read    = (state_q != HOLD);
    assign icache_address = pc_q;

    fetch_skid_buffer u_skid (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load),
        .load_inst_i (icache_rdata),
        .load_pc_i   (pc_inc),
        .flush_i     (redirect_valid),
        .id_stall_i  (id_stall),
        .consume_o   (consume),
        .slot_free_o (slot_free),
        .if_valid_o  (if_valid),
        .if_inst_o   (if_inst),
        .if_pc_o     (if_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            pending_pc_q <= RESET_PC;
        end else begin
            case (state_q)
                FETCH: begin
                    if (redirect_valid) begin
                        // Without a response the cache still owns pc_q; park the target.
                        if (icache_resp) begin
                            pc_q <= redirect_target;
                        end else begin
                            pending_pc_q <= redirect_target;
                            state_q      <= SQUASH;
                        end
                    end else if (icache_resp) begin
                        pc_q <= pc_inc;
                        if (!slot_free) begin
                            state_q <= HOLD;
                        end
                    end
                end
                SQUASH: begin
                    if (icache_resp) begin
                        pc_q    <= redirect_valid ? redirect_target : pending_pc_q;
                        state_q <= FETCH;
                    end else if (redirect_valid) begin
                        pending_pc_q <= redirect_target;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc_q    <= redirect_target;
                        state_q <= FETCH;
                    end else if (consume) begin
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q;
    logic [31:0] squash_count_q;
    logic        squash_evt;

    assign squash_evt = icache_resp &&
                        ((state_q == SQUASH) || ((state_q == FETCH) && redirect_valid));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q  <= '0;
            squash_count_q <= '0;
        end else begin
            if (load) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (squash_evt) begin
                squash_count_q <= squash_count_q + 32'd1;
            end
        end
    end

    assign if_fetch_count  = fetch_count_q;
    assign if_squash_count = squash_count_q;
`else
    assign if_fetch_count  = 32'd0;
    assign if_squash_count = 32'd0;
`endif

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined LC-3b core, directly upstream of instruction decode. Owns the fetch PC, runs the request/response handshake with the instruction cache, and delivers one (instruction, incremented PC) pair per accepted fetch to the decoder that builds the instruction packet. Absorbs decode back-pressure with a one-entry skid buffer and squashes in-flight fetches on a control-flow redirect.

## Interface
- RESET_PC, 16'h0000, fetch address after reset
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- icache_read  output  1  fetch request; held high until icache_resp
- icache_address  output  16  fetch address; stable while icache_read high
- icache_resp  input  1  one-cycle pulse; icache_rdata valid
- icache_rdata  input  16  fetched instruction word
- id_stall  input  1  decode cannot accept this cycle
- redirect_valid  input  1  one-cycle pulse, branch/jump/trap resolved
- redirect_pc  input  16  new fetch address
- if_valid  output  1  if_inst/if_pc hold a live instruction
- if_inst  output  16  instruction word (lc3b_word)
- if_pc  output  16  fetch address + 2 (lc3b_word)
- if_fetch_count  output  32  accepted fetches (see Configuration)
- if_squash_count  output  32  discarded responses (see Configuration)

## Operation
- Registers: pc_reg, pending_pc, output slot (valid/inst/pc), skid slot (valid/inst/pc), state.
- States FETCH, SQUASH, HOLD. icache_read = (state != HOLD); icache_address = pc_reg.
- Consume: if_valid && !id_stall. Output slot free = !if_valid or consumed this cycle.
- FETCH, resp, no redirect: pc_reg <= pc_reg + 2 (16-bit wrap, FFFE -> 0000). Slot free: output <= {rdata, pc_reg+2}; else skid <= same, state -> HOLD.
- HOLD: no request. On consume: output <= skid, skid invalid, state -> FETCH.
- Redirect (priority over resp/stall): output and skid invalidated; target = {redirect_pc[15:1], 1'b0}.
  - FETCH with resp same cycle: rdata discarded, pc_reg <= target, stay FETCH.
  - FETCH without resp: address must not change mid-request; pending_pc <= target, state -> SQUASH.
  - HOLD: pc_reg <= target, state -> FETCH.
  - SQUASH: pending_pc <= target (latest wins).
- SQUASH, resp: rdata discarded, pc_reg <= pending_pc, state -> FETCH. No output loads in SQUASH.
- Skid never loads while full (read low in HOLD).

## Timing
- Reset values: state FETCH, pc_reg RESET_PC, pending_pc RESET_PC, if_valid 0, if_inst 0, if_pc 0, skid invalid, counters 0. icache_read = 1 at address RESET_PC in first cycle after reset deasserts.
- Latency: resp at edge N -> if_valid/if_inst/if_pc visible after edge N. Next request address visible the cycle after resp.
- Throughput: 1 instruction/cycle when icache_resp returns in the cycle of the request.
- Redirect at edge N: if_valid 0 after edge N; first redirected instruction no earlier than the edge after the redirected request's resp.
- Reset mid-request: all state cleared immediately; in-flight response ignored by cache contract (cache also reset).
- Stall with both slots full: if_inst/if_pc held stable indefinitely.

## Configuration
- FETCH_PERF_CNT_EN defined: if_fetch_count increments on every resp loaded into output or skid; if_squash_count increments on every discarded resp; both 32-bit wrapping, cleared by reset.
- Undefined: counter registers not built; both ports driven constant 0.

## Structure
- lc3b_types package: fetch_state_t enum (FETCH, SQUASH, HOLD); reuse lc3b_word.
- One sub-module: fetch_skid_buffer (output slot + skid slot, load/consume/flush controls, if_* outputs). FSM, PC, pending_pc, counters in fetch_stage.

## Test plan
- Reset release, cache responds same cycle, id_stall 0 -> requests 0000,0002,0004; if_pc 0002,0004,0006 on consecutive cycles, if_valid stays 1.
- Cache 3-cycle latency -> icache_address held 0000 for 3 cycles with read high; one instruction per 3 cycles.
- id_stall held 4 cycles during streaming -> output then skid fill, icache_read drops; on release, skid drains in order, no lost/duplicated pc.
- Redirect to 3001 while request to 0004 outstanding -> address stays 0004 until resp, resp discarded, next request 3000, if_valid 0 meanwhile, squash count 1.
- Redirect coincident with resp at pc 0008 -> data dropped, next address = target; second redirect during SQUASH -> only the later target fetched.
- pc_reg FFFE fetched -> next address 0000, if_pc 0000.
